fp_mul_pipe: RTL and testbench

Native, fully pipelined IEEE-754 binary floating-point multiplier, parametrised in exponent and mantissa width. It serves FP32, FP16 and BF16 lanes of the mixed-precision core without a vendor IP.
- Adds valid/ready backpressure, round-to-nearest-even, exception flags and a configurable pipeline depth.
- Sits between the operand-fetch stage and the accumulator/writeback stage.

---
 rtl/fp_mul_pipe.sv | 199 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier with valid/ready handshake, RNE rounding and {nv,of,uf,nx} flags.
// Stage 1 registers the decoded operands and raw significand product; stage 2 rounds; later stages delay.
module fp_mul_pipe #(
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23,
   parameter int STAGES = 3
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   y,
   output logic [3:0]             flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2*MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W-1)) - 1);
   localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EZERO = '0;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   generate
      if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
         $error("fp_mul_pipe: STAGES must be in 2..6");
      end
   endgenerate

   logic                  advance;

   logic                  sa, sb;
   logic [EXP_W-1:0]      ea, eb;
   logic [MAN_W-1:0]      ma, mb;
   logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic                  sign_in, spec_in, spec_nv_in;
   logic [W-1:0]          spec_y_in;
   logic signed [EW-1:0]  exp_in;
   logic [PW-1:0]         prod_in;

   logic                  valid1_q, valid1_d;
   logic                  spec1_q, spec1_d;
   logic                  spec_nv1_q, spec_nv1_d;
   logic [W-1:0]          spec_y1_q, spec_y1_d;
   logic                  sign1_q, sign1_d;
   logic signed [EW-1:0]  exp1_q, exp1_d;
   logic [PW-1:0]         prod1_q, prod1_d;

   logic                  msb, guard, sticky, inc, carry;
   logic [PW-2:0]         norm;
   logic [MAN_W-1:0]      mant;
   logic [MAN_W:0]        sig_r;
   logic signed [EW-1:0]  exp_r;
   logic [W-1:0]          res_rnd;
   logic [3:0]            flg_rnd;

   logic                  valid_q [2:STAGES];
   logic                  valid_d [2:STAGES];
   logic [W-1:0]          res_q   [2:STAGES];
   logic [W-1:0]          res_d   [2:STAGES];
   logic [3:0]            flg_q   [2:STAGES];
   logic [3:0]            flg_d   [2:STAGES];

   assign out_valid = valid_q[STAGES];
   assign y         = res_q[STAGES];
   assign flags     = flg_q[STAGES];
   assign advance   = out_ready | ~out_valid;
   assign in_ready  = advance;

   // Operand decode; exponent-0 inputs are treated as zero (DAZ).
   always_comb begin
      {sa, ea, ma} = a;
      {sb, eb, mb} = b;
      a_zero  = (ea == '0);
      b_zero  = (eb == '0);
      a_inf   = (ea == '1) && (ma == '0);
      b_inf   = (eb == '1) && (mb == '0);
      a_nan   = (ea == '1) && (ma != '0);
      b_nan   = (eb == '1) && (mb != '0);
      a_snan  = a_nan && !ma[MAN_W-1];
      b_snan  = b_nan && !mb[MAN_W-1];
      sign_in = sa ^ sb;

      spec_in    = 1'b0;
      spec_nv_in = 1'b0;
      spec_y_in  = QNAN;
      if (a_nan || b_nan) begin
         spec_in    = 1'b1;
         spec_nv_in = a_snan || b_snan;
      end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
         spec_in    = 1'b1;
         spec_nv_in = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_in   = 1'b1;
         spec_y_in = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         spec_in   = 1'b1;
         spec_y_in = {sign_in, {(W-1){1'b0}}};
      end

      exp_in  = EW'(ea) + EW'(eb) - BIAS;
      prod_in = PW'({1'b1, ma}) * PW'({1'b1, mb});
   end

   // Normalise, round to nearest even, then range-check the post-round exponent.
   always_comb begin
      msb    = prod1_q[PW-1];
      norm   = msb ? prod1_q[PW-2:0] : {prod1_q[PW-3:0], 1'b0};
      mant   = norm[PW-2 -: MAN_W];
      guard  = norm[MAN_W];
      sticky = |norm[MAN_W-1:0];
      inc    = guard & (sticky | mant[0]);
      sig_r  = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
      carry  = sig_r[MAN_W];
      exp_r  = exp1_q + EW'(msb) + EW'(carry);

      // On a round carry the low mantissa bits are already zero, i.e. 1.0 at the bumped exponent.
      res_rnd = {sign1_q, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
      flg_rnd = {3'b000, guard | sticky};
      if (spec1_q) begin
         res_rnd = spec_y1_q;
         flg_rnd = {spec_nv1_q, 3'b000};
      end else if (exp_r >= EMAX) begin
         res_rnd = {sign1_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_rnd = 4'b0101;
      end else if (exp_r <= EZERO) begin
         res_rnd = {sign1_q, {(W-1){1'b0}}};
         flg_rnd = 4'b0011;
      end
   end

   // Whole pipe shifts together (bubbles included) or holds together.
   always_comb begin
      valid1_d   = valid1_q;
      spec1_d    = spec1_q;
      spec_nv1_d = spec_nv1_q;
      spec_y1_d  = spec_y1_q;
      sign1_d    = sign1_q;
      exp1_d     = exp1_q;
      prod1_d    = prod1_q;
      for (int k = 2; k <= STAGES; k++) begin
         valid_d[k] = valid_q[k];
         res_d[k]   = res_q[k];
         flg_d[k]   = flg_q[k];
      end
      if (advance) begin
         valid1_d   = in_valid;
         spec1_d    = spec_in;
         spec_nv1_d = spec_nv_in;
         spec_y1_d  = spec_y_in;
         sign1_d    = sign_in;
         exp1_d     = exp_in;
         prod1_d    = prod_in;
         valid_d[2] = valid1_q;
         res_d[2]   = res_rnd;
         flg_d[2]   = flg_rnd;
         for (int k = 3; k <= STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            res_d[k]   = res_q[k-1];
            flg_d[k]   = flg_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid1_q   <= 1'b0;
         spec1_q    <= 1'b0;
         spec_nv1_q <= 1'b0;
         spec_y1_q  <= '0;
         sign1_q    <= 1'b0;
         exp1_q     <= '0;
         prod1_q    <= '0;
         for (int k = 2; k <= STAGES; k++) begin
            valid_q[k] <= 1'b0;
            res_q[k]   <= '0;
            flg_q[k]   <= '0;
         end
      end else begin
         valid1_q   <= valid1_d;
         spec1_q    <= spec1_d;
         spec_nv1_q <= spec_nv1_d;
         spec_y1_q  <= spec_y1_d;
         sign1_q    <= sign1_d;
         exp1_q     <= exp1_d;
         prod1_q    <= prod1_d;
         for (int k = 2; k <= STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            res_q[k]   <= res_d[k];
            flg_q[k]   <= flg_d[k];
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: an FP32/3-stage instance and an FP16/2-stage instance,
// directed vectors with hand-computed results popped by per-instance monitors.
module tb_fp_mul_pipe;

   typedef struct {
      logic [31:0] y;
      logic [3:0]  f;
      int          cyc;
      bit          lat;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic        in_valid32, in_ready32, out_valid32, out_ready32;
   logic [31:0] a32, b32, y32;
   logic [3:0]  flags32;
   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [15:0] a16, b16, y16;
   logic [3:0]  flags16;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   exp_t q32[$];
   exp_t q16[$];

   logic [31:0] bp_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
   logic [31:0] bp_y [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                             32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3)) dut32 (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
      .out_valid(out_valid32), .out_ready(out_ready32), .y(y32), .flags(flags32)
   );

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(2)) dut16 (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
      .out_valid(out_valid16), .out_ready(out_ready16), .y(y16), .flags(flags16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic applyStimulus32(input logic [31:0] av, input logic [31:0] bv,
                                  input logic [31:0] ey, input logic [3:0] ef, input bit lat);
      int waits = 0;
      a32 = av;
      b32 = bv;
      in_valid32 = 1'b1;
      #1;
      while (!in_ready32 && waits < 50) begin
         @(negedge clk);
         #1;
         waits++;
      end
      checkOutput("accept32", 32'(in_ready32), 32'd1);
      if (in_ready32) q32.push_back('{y: ey, f: ef, cyc: cyc, lat: lat});
      @(negedge clk);
      in_valid32 = 1'b0;
   endtask

   task automatic applyStimulus16(input logic [15:0] av, input logic [15:0] bv,
                                  input logic [15:0] ey, input logic [3:0] ef, input bit lat);
      int waits = 0;
      a16 = av;
      b16 = bv;
      in_valid16 = 1'b1;
      #1;
      while (!in_ready16 && waits < 50) begin
         @(negedge clk);
         #1;
         waits++;
      end
      checkOutput("accept16", 32'(in_ready16), 32'd1);
      if (in_ready16) q16.push_back('{y: 32'(ey), f: ef, cyc: cyc, lat: lat});
      @(negedge clk);
      in_valid16 = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q32.size() != 0 || q16.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      checkOutput("drain_q32", 32'(q32.size()), 32'd0);
      checkOutput("drain_q16", 32'(q16.size()), 32'd0);
   endtask

   // Monitors sample mid-cycle; while stalled the head entry is re-checked every cycle.
   always begin : mon32
      exp_t e;
      @(negedge clk);
      #2;
      if (rstn && out_valid32) begin
         if (q32.size() == 0) begin
            checkOutput("spurious_out_valid32", 32'(out_valid32), 32'd0);
         end else begin
            e = q32[0];
            checkOutput("y32", y32, e.y);
            checkOutput("flags32", 32'(flags32), 32'(e.f));
            if (!out_ready32) begin
               checkOutput("in_ready_stall32", 32'(in_ready32), 32'd0);
            end else begin
               void'(q32.pop_front());
               if (e.lat) checkOutput("latency32", cyc - e.cyc, 32'd3);
            end
         end
      end
   end

   always begin : mon16
      exp_t e;
      @(negedge clk);
      #2;
      if (rstn && out_valid16) begin
         if (q16.size() == 0) begin
            checkOutput("spurious_out_valid16", 32'(out_valid16), 32'd0);
         end else begin
            e = q16[0];
            checkOutput("y16", 32'(y16), e.y);
            checkOutput("flags16", 32'(flags16), 32'(e.f));
            if (!out_ready16) begin
               checkOutput("in_ready_stall16", 32'(in_ready16), 32'd0);
            end else begin
               void'(q16.pop_front());
               if (e.lat) checkOutput("latency16", cyc - e.cyc, 32'd2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      in_valid32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b1;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      checkOutput("rst_out_valid32", 32'(out_valid32), 32'd0);
      checkOutput("rst_y32", y32, 32'd0);
      checkOutput("rst_flags32", 32'(flags32), 32'd0);
      checkOutput("rst_in_ready32", 32'(in_ready32), 32'd1);
      checkOutput("rst_out_valid16", 32'(out_valid16), 32'd0);
      checkOutput("rst_y16", 32'(y16), 32'd0);
      @(negedge clk);

      // Basic products, rounding, exceptions and specials.
      applyStimulus32(32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, 1'b1);
      applyStimulus32(32'h3F800800, 32'h3F800800, 32'h3F801000, 4'h1, 1'b1);
      applyStimulus32(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1, 1'b1);
      applyStimulus32(32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'h1, 1'b1);
      applyStimulus32(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8, 1'b1);
      applyStimulus32(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'h5, 1'b1);
      applyStimulus32(32'h00800000, 32'h3F000000, 32'h00000000, 4'h3, 1'b1);
      applyStimulus32(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8, 1'b1);
      applyStimulus32(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0, 1'b1);
      applyStimulus32(32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0, 1'b1);
      applyStimulus32(32'h80000000, 32'h40000000, 32'h80000000, 4'h0, 1'b1);
      applyStimulus32(32'h00000001, 32'h40000000, 32'h00000000, 4'h0, 1'b1);
      applyStimulus32(32'hC0000000, 32'h3F800000, 32'hC0000000, 4'h0, 1'b1);
      drain();

      // Back-to-back stream with a 5-cycle downstream stall once results appear.
      fork
         begin
            repeat (3) @(negedge clk);
            out_ready32 = 1'b0;
            repeat (5) @(negedge clk);
            out_ready32 = 1'b1;
         end
      join_none
      for (int i = 0; i < 8; i++) applyStimulus32(bp_a[i], 32'h40000000, bp_y[i], 4'h0, 1'b0);
      drain();

      // Reset with a full pipe held by backpressure; those results must never emerge.
      out_ready32 = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus32(bp_a[i], 32'h40000000, bp_y[i], 4'h0, 1'b0);
      rstn = 1'b0;
      q32.delete();
      @(negedge clk);
      rstn = 1'b1;
      out_ready32 = 1'b1;
      #1;
      checkOutput("rst_mid_out_valid32", 32'(out_valid32), 32'd0);
      checkOutput("rst_mid_y32", y32, 32'd0);
      checkOutput("rst_mid_flags32", 32'(flags32), 32'd0);
      @(negedge clk);
      applyStimulus32(32'h40400000, 32'h40400000, 32'h41100000, 4'h0, 1'b1);
      drain();

      // Half precision, two stages.
      applyStimulus16(16'h3E00, 16'h4000, 16'h4200, 4'h0, 1'b1);
      applyStimulus16(16'h7BFF, 16'h4000, 16'h7C00, 4'h5, 1'b1);
      applyStimulus16(16'hFC00, 16'h0000, 16'h7E00, 4'h8, 1'b1);
      applyStimulus16(16'h3C01, 16'h3C01, 16'h3C02, 4'h1, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
